// File: rtl/bip_report_pkg.sv
// Shared types and constants for the BIP result reporter.
// BIP_REPORT_CHECKSUM_EN adds a trailing XOR checksum byte to the frame.
package bip_report_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_e;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  // Frame: header, inst_count, accumulator bytes MSB-first, optional checksum.
  function automatic int unsigned frame_len(input int unsigned data_w);
`ifdef BIP_REPORT_CHECKSUM_EN
    return 3 + data_w / 8;
`else
    return 2 + data_w / 8;
`endif
  endfunction

  localparam int unsigned FRAME_LEN = frame_len(16);

endpackage

// File: rtl/bip_result_reporter_if.sv
// Valid/ready byte stream from the result reporter to the UART transmitter.
interface bip_result_reporter_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/bip_result_reporter.sv
// Snapshots BIP accumulator/instruction count on a rising done flag and streams
// them as a byte frame to the UART TX. Optional checksum: BIP_REPORT_CHECKSUM_EN.
module bip_result_reporter
  import bip_report_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned COUNT_W = 8,
  parameter logic [7:0]  HEADER  = DEFAULT_HEADER
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_done,
  input  logic [DATA_W-1:0]         i_accumulator,
  input  logic [COUNT_W-1:0]        i_inst_count,
  bip_result_reporter_if.master     tx,
  output logic                      o_busy,
  output logic                      o_sent
);

  localparam int unsigned NUM_ACC_BYTES = DATA_W / 8;
  localparam int unsigned LEN           = frame_len(DATA_W);
  localparam int unsigned IDX_W         = $clog2(LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0]    acc_q, acc_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 done_q, done_d;
  logic                 trigger;
  logic [7:0]           tx_byte;
`ifdef BIP_REPORT_CHECKSUM_EN
  logic [7:0]           chk_q, chk_d;
  logic [7:0]           chk_calc;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      count_q <= '0;
      // A done level already high at reset release must not start a frame.
      done_q  <= 1'b1;
`ifdef BIP_REPORT_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      done_q  <= done_d;
`ifdef BIP_REPORT_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

`ifdef BIP_REPORT_CHECKSUM_EN
  always_comb begin
    chk_calc = i_inst_count;
    for (int unsigned b = 0; b < NUM_ACC_BYTES; b++) begin
      chk_calc = chk_calc ^ i_accumulator[8*b +: 8];
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    count_d = count_q;
    done_d  = i_done;
`ifdef BIP_REPORT_CHECKSUM_EN
    chk_d   = chk_q;
`endif
    trigger = i_done & ~done_q;

    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          acc_d   = i_accumulator;
          count_d = i_inst_count;
          idx_d   = '0;
`ifdef BIP_REPORT_CHECKSUM_EN
          chk_d   = chk_calc;
`endif
          state_d = SEND;
        end
      end
      SEND: begin
        // Valid is asserted for the whole of SEND, so ready alone means a transfer.
        if (tx.tx_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    tx_byte = '0;
    case (idx_q)
      IDX_W'(0): tx_byte = HEADER;
      IDX_W'(1): tx_byte = count_q;
`ifdef BIP_REPORT_CHECKSUM_EN
      LAST_IDX:  tx_byte = chk_q;
`endif
      default: begin
        for (int unsigned b = 0; b < NUM_ACC_BYTES; b++) begin
          if (idx_q == IDX_W'(2 + b)) begin
            tx_byte = acc_q[DATA_W-1-8*b -: 8];
          end
        end
      end
    endcase
  end

  always_comb begin
    tx.tx_valid = (state_q == SEND);
    tx.tx_data  = (state_q == SEND) ? tx_byte : '0;
    o_busy      = (state_q != IDLE);
    o_sent      = (state_q == DONE);
  end

endmodule

// File: tb/tb_bip_result_reporter.sv
// Self-checking bench for bip_result_reporter: a scoreboard of expected bytes is
// filled when a frame is triggered and drained by the byte-stream monitor.
module tb_bip_result_reporter;

`ifdef BIP_REPORT_CHECKSUM_EN
  localparam int FLEN = 5;
`else
  localparam int FLEN = 4;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        done;
  logic [15:0] acc;
  logic [7:0]  cnt;
  logic        busy;
  logic        sent;

  bip_result_reporter_if tx_if();

  bip_result_reporter #(
    .DATA_W (16),
    .COUNT_W(8),
    .HEADER (8'hA5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_done       (done),
    .i_accumulator(acc),
    .i_inst_count (cnt),
    .tx           (tx_if),
    .o_busy       (busy),
    .o_sent       (sent)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  int         sent_cnt = 0;
  logic [7:0] sb[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;

  function automatic logic [7:0] exp_byte(input logic [15:0] a, input logic [7:0] c, input int k);
    case (k)
      0:       return 8'hA5;
      1:       return c;
      2:       return a[15:8];
      3:       return a[7:0];
      default: return c ^ a[15:8] ^ a[7:0];
    endcase
  endfunction

  function automatic void push_frame(input logic [15:0] a, input logic [7:0] c);
    for (int k = 0; k < FLEN; k++) sb.push_back(exp_byte(a, c, k));
  endfunction

  // Byte-stream monitor: scoreboard pops on transfers, stall stability, o_sent count.
  always @(negedge clk) begin
    logic [7:0] exp;
    if (sent === 1'b1) sent_cnt++;
    if (prev_stall) begin
      checks++;
      if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== prev_data) begin
        failures++;
        $display("FAIL stall_hold: valid=%b data=%h required valid=1 data=%h",
                 tx_if.tx_valid, tx_if.tx_data, prev_data);
      end
    end
    prev_stall <= (rst === 1'b0 && tx_if.tx_valid === 1'b1 && tx_if.tx_ready === 1'b0);
    prev_data  <= tx_if.tx_data;
    if (rst === 1'b0 && tx_if.tx_valid === 1'b1 && tx_if.tx_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_byte: data=%h required no transfer", tx_if.tx_data);
      end else begin
        exp = sb.pop_front();
        if (tx_if.tx_data !== exp) begin
          failures++;
          $display("FAIL frame_byte: data=%h required %h", tx_if.tx_data, exp);
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (busy === 1'b0) return;
    end
    checks++;
    failures++;
    $display("FAIL idle_timeout: busy=%b required 0 within %0d cycles", busy, budget);
  endtask

  task automatic test_reset;
    rst = 1'b1; done = 1'b0; acc = '0; cnt = '0; tx_if.tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (tx_if.tx_valid !== 1'b0 || tx_if.tx_data !== 8'h00 || busy !== 1'b0 || sent !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b data=%h busy=%b sent=%b required 0 00 0 0",
               tx_if.tx_valid, tx_if.tx_data, busy, sent);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_basic;
    int s0 = sent_cnt;
    tx_if.tx_ready = 1'b1; acc = 16'h1234; cnt = 8'h07;
    @(posedge clk); #1 done = 1'b1;
    push_frame(acc, cnt);
    @(posedge clk);
    for (int k = 0; k < FLEN; k++) begin
      @(negedge clk);
      checks++;
      if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== exp_byte(16'h1234, 8'h07, k)) begin
        failures++;
        $display("FAIL basic_byte%0d: valid=%b data=%h required 1 %h", k,
                 tx_if.tx_valid, tx_if.tx_data, exp_byte(16'h1234, 8'h07, k));
      end
    end
    @(negedge clk);
    checks++;
    if (sent !== 1'b1 || tx_if.tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_sent: sent=%b valid=%b required 1 0", sent, tx_if.tx_valid);
    end
    @(negedge clk);
    checks++;
    if (sent !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle: sent=%b busy=%b required 0 0", sent, busy);
    end
    @(posedge clk); #1 done = 1'b0;
    checks++;
    if (sent_cnt - s0 !== 1 || sb.size() != 0) begin
      failures++;
      $display("FAIL basic_count: frames=%0d left=%0d required 1 0", sent_cnt - s0, sb.size());
    end
  endtask

  task automatic test_backpressure;
    int   s0 = sent_cnt;
    logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit   fin = 1'b0;
    acc = 16'h1234; cnt = 8'h07; tx_if.tx_ready = 1'b1;
    @(posedge clk); #1 done = 1'b1;
    push_frame(acc, cnt);
    for (int c = 0; c < 100 && !fin; c++) begin
      @(posedge clk); #1;
      tx_if.tx_ready = pat[c % 4];
      if (c > 0 && busy === 1'b0) fin = 1'b1;
    end
    tx_if.tx_ready = 1'b1; done = 1'b0;
    checks++;
    if (!fin || sent_cnt - s0 !== 1 || sb.size() != 0) begin
      failures++;
      $display("FAIL backpressure: done=%b frames=%0d left=%0d required 1 1 0",
               fin, sent_cnt - s0, sb.size());
    end
  endtask

  task automatic test_snapshot;
    int s0 = sent_cnt;
    tx_if.tx_ready = 1'b1; acc = 16'h1234; cnt = 8'h07;
    @(posedge clk); #1 done = 1'b1;
    push_frame(acc, cnt);
    @(posedge clk); #1 acc = 16'hFFFF; cnt = 8'hFF;
    wait_idle(50);
    @(posedge clk); #1 done = 1'b0;
    checks++;
    if (sent_cnt - s0 !== 1 || sb.size() != 0) begin
      failures++;
      $display("FAIL snapshot: frames=%0d left=%0d required 1 0", sent_cnt - s0, sb.size());
    end
  endtask

  task automatic test_hold_high;
    int s0 = sent_cnt;
    tx_if.tx_ready = 1'b1; acc = 16'hBEEF; cnt = 8'h3C;
    @(posedge clk); #1 done = 1'b1;
    push_frame(acc, cnt);
    repeat (50) @(posedge clk);
    #1 done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sent_cnt - s0 !== 1 || sb.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL hold_high: frames=%0d left=%0d busy=%b required 1 0 0",
               sent_cnt - s0, sb.size(), busy);
    end
  endtask

  task automatic test_retrigger_busy;
    int s0 = sent_cnt;
    tx_if.tx_ready = 1'b1; acc = 16'h0F0F; cnt = 8'h81;
    @(posedge clk); #1 done = 1'b1;
    push_frame(acc, cnt);
    @(posedge clk); #1 done = 1'b0;
    @(posedge clk); #1 done = 1'b1;
    @(posedge clk); #1 done = 1'b0;
    wait_idle(50);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (sent_cnt - s0 !== 1 || sb.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL retrigger_busy: frames=%0d left=%0d busy=%b required 1 0 0",
               sent_cnt - s0, sb.size(), busy);
    end
  endtask

  task automatic test_back_to_back;
    int s0 = sent_cnt;
    tx_if.tx_ready = 1'b1; acc = 16'hCAFE; cnt = 8'h10;
    @(posedge clk); #1 done = 1'b1;
    push_frame(acc, cnt);
    @(posedge clk); #1 done = 1'b0;
    wait_idle(50);
    acc = 16'h0001; cnt = 8'hFE; done = 1'b1;
    push_frame(acc, cnt);
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL min_gap_accept: busy=%b required 1", busy);
    end
    wait_idle(50);
    @(posedge clk); #1 done = 1'b0;
    checks++;
    if (sent_cnt - s0 !== 2 || sb.size() != 0) begin
      failures++;
      $display("FAIL back_to_back: frames=%0d left=%0d required 2 0", sent_cnt - s0, sb.size());
    end
  endtask

  task automatic test_reset_midframe;
    int s0 = sent_cnt;
    tx_if.tx_ready = 1'b1; acc = 16'h5AA5; cnt = 8'h42;
    @(posedge clk); #1 done = 1'b1;
    push_frame(acc, cnt);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (tx_if.tx_valid !== 1'b0 || tx_if.tx_data !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_midframe: valid=%b data=%h busy=%b required 0 00 0",
               tx_if.tx_valid, tx_if.tx_data, busy);
    end
    rst = 1'b0;
    checks++;
    if (sb.size() != FLEN - 2) begin
      failures++;
      $display("FAIL reset_partial: left=%0d required %0d", sb.size(), FLEN - 2);
    end
    sb.delete();
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (sent_cnt - s0 !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_done_high: frames=%0d busy=%b required 0 0", sent_cnt - s0, busy);
    end
    done = 1'b0;
    @(posedge clk); #1 done = 1'b1; acc = 16'h8001; cnt = 8'h00;
    push_frame(acc, cnt);
    wait_idle(50);
    @(posedge clk); #1 done = 1'b0;
    checks++;
    if (sent_cnt - s0 !== 1 || sb.size() != 0) begin
      failures++;
      $display("FAIL reset_recover: frames=%0d left=%0d required 1 0", sent_cnt - s0, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_snapshot();
    test_hold_high();
    test_retrigger_busy();
    test_back_to_back();
    test_reset_midframe();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
